// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - coin values, vending FSM state encoding and price-table lookup
package vend_pkg;

    localparam int unsigned COIN_Q = 25;
    localparam int unsigned COIN_D = 10;
    localparam int unsigned COIN_N = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CREDIT = 2'd1,
        ST_VEND   = 2'd2,
        ST_CHANGE = 2'd3
    } vend_state_t;

    // Table is zero-extended to 256 bits so any N_PROD x CR_W up to 8 x 32 fits.
    function automatic logic [31:0] price_of(input logic [255:0] vec,
                                             input int unsigned  idx,
                                             input int unsigned  w);
        logic [255:0] sh;
        logic [32:0]  mask;
        sh   = vec >> (idx * w);
        mask = (33'd1 << w) - 33'd1;
        return sh[31:0] & mask[31:0];
    endfunction

endpackage

// File: rtl/vend_stock.sv
// rtl/vend_stock.sv - per-product 4-bit stock counters with sold-out decode
module vend_stock #(
    parameter int N_PROD     = 4,
    parameter int STOCK_INIT = 3
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic                      Dec,
    input  logic [$clog2(N_PROD)-1:0] Idx,
    output logic [N_PROD-1:0]         SoldOut
);

    logic [3:0] stock [N_PROD];

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            for (int i = 0; i < N_PROD; i++)
                stock[i] <= 4'(STOCK_INIT);
        end else if (Dec && (32'(Idx) < N_PROD) && (stock[Idx] != 4'd0)) begin
            stock[Idx] <= stock[Idx] - 4'd1;
        end
    end

    always_comb begin
        SoldOut = '0;
        for (int i = 0; i < N_PROD; i++)
            SoldOut[i] = (stock[i] == 4'd0);
    end

endmodule

// File: rtl/multi_product_vend.sv
// rtl/multi_product_vend.sv - multi-product vending controller: credit, vend, change
module multi_product_vend
    import vend_pkg::*;
#(
    parameter int                     N_PROD     = 4,
    parameter int                     CR_W       = 8,
    parameter logic [N_PROD*CR_W-1:0] PRICE_VEC  = {8'd65, 8'd35, 8'd50, 8'd25},
    parameter int                     MAX_CREDIT = 100,
    parameter int                     STOCK_INIT = 3,
    parameter bit                     AUTO_VEND  = 1'b0
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic                      Q,
    input  logic                      D,
    input  logic                      N,
    input  logic [$clog2(N_PROD)-1:0] Sel,
    input  logic                      Buy,
    input  logic                      Cancel,
    output logic                      Candy,
    output logic [$clog2(N_PROD)-1:0] VendId,
    output logic [CR_W-1:0]           Change,
    output logic                      ChangeValid,
    output logic [CR_W-1:0]           Credit,
    output logic [N_PROD-1:0]         SoldOut,
    output logic                      CoinReject,
    output logic                      Deny
);

    vend_state_t                state;
    logic [CR_W-1:0]            price_q;
    logic [$clog2(N_PROD)-1:0]  sel_q;
    logic                       auto_hold;

    logic [CR_W-1:0] sel_price;
    logic [CR_W-1:0] coin_val;
    logic [CR_W:0]   coin_sum;
    logic [1:0]      n_coins;
    logic            buy_req;
    logic            vend_ok;
    logic            coin_ok;

    always_comb begin
        sel_price = CR_W'(price_of(256'(PRICE_VEC), 32'(Sel), 32'(CR_W)));
        coin_val  = '0;
        if (Q)      coin_val = CR_W'(COIN_Q);
        else if (D) coin_val = CR_W'(COIN_D);
        else if (N) coin_val = CR_W'(COIN_N);
        n_coins  = {1'b0, Q} + {1'b0, D} + {1'b0, N};
        coin_sum = {1'b0, Credit} + {1'b0, coin_val};
        // Auto mode stops retrying a sold-out product until credit or Sel changes.
        buy_req  = Buy || (AUTO_VEND && (state == ST_CREDIT) && (Credit >= sel_price) && !auto_hold);
        vend_ok  = (state == ST_CREDIT) && !Cancel && buy_req &&
                   (Credit >= sel_price) && !SoldOut[Sel];
        coin_ok  = (n_coins == 2'd1) && !buy_req && !Cancel &&
                   (coin_sum <= (CR_W+1)'(MAX_CREDIT));
    end

    vend_stock #(
        .N_PROD     (N_PROD),
        .STOCK_INIT (STOCK_INIT)
    ) u_stock (
        .Clk     (Clk),
        .Rst     (Rst),
        .Dec     (vend_ok),
        .Idx     (Sel),
        .SoldOut (SoldOut)
    );

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state       <= ST_IDLE;
            Credit      <= '0;
            Candy       <= 1'b0;
            VendId      <= '0;
            Change      <= '0;
            ChangeValid <= 1'b0;
            CoinReject  <= 1'b0;
            Deny        <= 1'b0;
            price_q     <= '0;
            sel_q       <= '0;
            auto_hold   <= 1'b0;
        end else begin
            Candy       <= 1'b0;
            Change      <= '0;
            ChangeValid <= 1'b0;
            CoinReject  <= 1'b0;
            Deny        <= 1'b0;
            sel_q       <= Sel;
            if (Sel != sel_q)
                auto_hold <= 1'b0;
            case (state)
                ST_IDLE, ST_CREDIT: begin
                    if ((state == ST_CREDIT) && Cancel) begin
                        state       <= ST_CHANGE;
                        Change      <= Credit;
                        ChangeValid <= 1'b1;
                        Credit      <= '0;
                    end else if (vend_ok) begin
                        state   <= ST_VEND;
                        Candy   <= 1'b1;
                        VendId  <= Sel;
                        price_q <= sel_price;
                    end else if (buy_req) begin
                        Deny      <= 1'b1;
                        auto_hold <= 1'b1;
                    end
                    if (coin_ok) begin
                        state     <= ST_CREDIT;
                        Credit    <= coin_sum[CR_W-1:0];
                        auto_hold <= 1'b0;
                    end else if (n_coins != 2'd0) begin
                        CoinReject <= 1'b1;
                    end
                end
                ST_VEND: begin
                    state       <= ST_CHANGE;
                    Change      <= Credit - price_q;
                    ChangeValid <= 1'b1;
                    Credit      <= '0;
                    CoinReject  <= (n_coins != 2'd0);
                end
                default: begin
                    state      <= ST_IDLE;
                    auto_hold  <= 1'b0;
                    CoinReject <= (n_coins != 2'd0);
                end
            endcase
        end
    end

endmodule
